// File: rtl/uart_pkg.sv
// Shared state type, character constants and sizing helper for the UART echo path.
// The SEND_LF state only exists when ECHO_CRLF_EN is defined.
package uart_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

`ifdef ECHO_CRLF_EN
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, SEND_LF} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_t;
`endif

  // Level counter must reach DEPTH itself, hence one bit wider than the pointers.
  function automatic int unsigned level_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO without fall-through: a word pushed this cycle is poppable next cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo path between UART RX and TX: FIFO buffering, start/tx_ready handshake with retry,
// overflow and drop statistics. Define ECHO_CRLF_EN to append LF after every echoed CR.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACK_TO = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  output logic [level_w(DEPTH)-1:0]  fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int unsigned RW = $clog2(ACK_TO + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(ACK_TO - 1);

  tx_state_t         state, state_d;
  logic [DATA_W-1:0] tx_data_d;
  logic              tx_start_d;
  logic [RW-1:0]     retry_cnt, retry_d;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              drop;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign drop = rx_valid && full && !pop;

  always_comb begin
    state_d    = state;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    retry_d    = retry_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          pop        = 1'b1;
          retry_d    = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Transmitter never went busy: re-pulse start with the same word, no pop.
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (retry_cnt == RETRY_LAST) begin
          tx_start_d = 1'b1;
          retry_d    = '0;
        end else begin
          retry_d = retry_cnt + RW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
`ifdef ECHO_CRLF_EN
          state_d = (tx_data[7:0] == CR) ? SEND_LF : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef ECHO_CRLF_EN
      SEND_LF: begin
        if (tx_ready) begin
          tx_data_d  = DATA_W'(LF);
          tx_start_d = 1'b1;
          retry_d    = '0;
          state_d    = WAIT_BUSY;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      retry_cnt  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state     <= state_d;
      tx_data   <= tx_data_d;
      tx_start  <= tx_start_d;
      retry_cnt <= retry_d;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural transmitter.
module tb_uart_echo_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;
  localparam int ACK_TO = 64;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef ECHO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic [LW-1:0]     fifo_level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;

  uart_echo_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .ACK_TO (ACK_TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural transmitter: busy for busy_len cycles after taking a start,
  // ignores the next `ign` starts, and is forced busy while hold=1.
  int   busy_len = 10;
  int   ign      = 0;
  int   busy     = 0;
  bit   hold     = 1'b0;
  logic txs;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      txs = tx_start && reset;
      @(posedge clk);
      #1;
      if (txs) begin
        if (ign > 0) ign--;
        else busy = busy_len;
      end
      if (busy > 0) begin
        tx_ready = 1'b0;
        busy--;
      end else begin
        tx_ready = !hold;
      end
    end
  end

  // Reference model: FIFO contents as a queue, drop statistics, handshake bookkeeping.
  logic [7:0]  mq[$];
  logic [7:0]  sent[$];
  logic [7:0]  start_dat[$];
  int          start_cyc[$];
  int          mdrops  = 0;
  bit          movf    = 1'b0;
  bit          pending = 1'b0;
  bit          lf_due  = 1'b0;
  bit          popped;
  logic        prev_vld   = 1'b0;
  logic [7:0]  prev_dat   = '0;
  logic        prev_start = 1'b0;
  logic [7:0]  prev_txd   = '0;
  int          cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        mq.delete();
        mdrops = 0; movf = 1'b0; pending = 1'b0; lf_due = 1'b0;
        prev_vld = 1'b0; prev_start = 1'b0; prev_txd = '0;
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drops", 32'(drop_count), 0);
      end else begin
        popped = 1'b0;
        if (tx_start) begin
          start_cyc.push_back(cyc);
          start_dat.push_back(tx_data);
          chk("start_gap", 32'(prev_start), 0);
          if (pending) begin
            chk("retry_data", 32'(tx_data), 32'(prev_txd));
          end else begin
            if (lf_due) begin
              chk("lf_data", 32'(tx_data), 32'h0A);
              lf_due = 1'b0;
            end else begin
              chk("q_nonempty", 32'(mq.size() != 0), 1);
              if (mq.size() != 0) begin
                chk("tx_order", 32'(tx_data), 32'(mq[0]));
                lf_due = CRLF && (mq[0] == 8'h0D);
                void'(mq.pop_front());
                popped = 1'b1;
              end
            end
            sent.push_back(tx_data);
          end
          pending = 1'b1;
        end else begin
          chk("data_hold", 32'(tx_data), 32'(prev_txd));
        end
        if (prev_vld) begin
          if (mq.size() < DEPTH) mq.push_back(prev_dat);
          else begin
            movf = 1'b1;
            if (mdrops < 255) mdrops++;
          end
        end
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("ovf", 32'(overflow), 32'(movf));
        chk("drops", 32'(drop_count), 32'(mdrops));
        if (popped && mq.size() > DEPTH) chk("model_size", 32'(mq.size()), DEPTH);
        prev_vld   = rx_valid;
        prev_dat   = rx_data;
        prev_start = tx_start;
        prev_txd   = tx_data;
        if (!tx_ready) pending = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    cycles(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int target, input int budget);
    int t = 0;
    while (sent.size() < target && t < budget) begin
      cycles(1);
      t++;
    end
    chk(tag, 32'(sent.size() >= target), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n0;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    cycles(3);
    reset = 1'b1;
    cycles(3);

    // Single word echo
    busy_len = 10;
    base = sent.size(); n0 = start_cyc.size();
    send(8'h41);
    wait_sent("t1_timeout", base + 1, 40);
    cycles(15);
    chk("t1_starts", 32'(start_cyc.size() - n0), 1);
    chk("t1_data", 32'(sent[base]), 32'h41);
    chk("t1_level", 32'(fifo_level), 0);

    // Burst while transmitter busy, then drain in order
    hold = 1'b1; cycles(2);
    base = sent.size(); n0 = start_cyc.size();
    for (int i = 1; i <= 5; i++) send(8'(i));
    cycles(1);
    chk("t2_level", 32'(fifo_level), 5);
    busy_len = 3; hold = 1'b0;
    wait_sent("t2_timeout", base + 5, 200);
    cycles(10);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(sent[base + i]), 32'(i + 1));
    chk("t2_starts", 32'(start_cyc.size() - n0), 5);

    // Overflow: 20 words into 16 entries
    hold = 1'b1; cycles(2);
    base = sent.size();
    for (int i = 0; i < 20; i++) send(8'(8'h80 + i));
    cycles(1);
    chk("t3_level", 32'(fifo_level), 16);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drops", 32'(drop_count), 4);
    hold = 1'b0;
    wait_sent("t3_timeout", base + 16, 400);
    cycles(20);
    chk("t3_count", 32'(sent.size() - base), 16);
    for (int i = 0; i < 16; i++) chk("t3_order", 32'(sent[base + i]), 32'(8'h80 + i));

    // Ignored start -> retry exactly ACK_TO cycles later, single pop
    busy_len = 5; ign = 1;
    base = sent.size(); n0 = start_cyc.size();
    send(8'h5A);
    for (int t = 0; t < 200 && start_cyc.size() < n0 + 2; t++) cycles(1);
    cycles(10);
    chk("t4_starts", 32'(start_cyc.size() - n0), 2);
    chk("t4_gap", 32'(start_cyc[n0 + 1] - start_cyc[n0]), ACK_TO);
    chk("t4_data0", 32'(start_dat[n0]), 32'h5A);
    chk("t4_data1", 32'(start_dat[n0 + 1]), 32'h5A);
    chk("t4_words", 32'(sent.size() - base), 1);
    chk("t4_level", 32'(fifo_level), 0);

    // Reset in WAIT_DONE with 3 words queued
    hold = 1'b1; cycles(2);
    busy_len = 30;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
    cycles(1);
    n0 = start_cyc.size();
    hold = 1'b0;
    for (int t = 0; t < 20 && start_cyc.size() == n0; t++) cycles(1);
    cycles(5);
    chk("t5_level", 32'(fifo_level), 3);
    reset = 1'b0;
    #1;
    chk("t5_start", 32'(tx_start), 0);
    chk("t5_data", 32'(tx_data), 0);
    chk("t5_lvl0", 32'(fifo_level), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_drops", 32'(drop_count), 0);
    cycles(2);
    reset = 1'b1;
    n0 = start_cyc.size();
    cycles(40);
    chk("t5_quiet", 32'(start_cyc.size() - n0), 0);
    base = sent.size();
    send(8'h77);
    wait_sent("t5_timeout", base + 1, 60);
    chk("t5_new", 32'(sent[base]), 32'h77);
    cycles(40);

    // CR handling
    busy_len = 4;
    base = sent.size();
    send(8'h0D);
    send(8'h41);
    wait_sent("t6_timeout", base + (CRLF ? 3 : 2), 100);
    cycles(10);
    chk("t6_count", 32'(sent.size() - base), CRLF ? 3 : 2);
    chk("t6_cr", 32'(sent[base]), 32'h0D);
    chk("t6_next", 32'(sent[base + 1]), CRLF ? 32'h0A : 32'h41);
    if (CRLF) chk("t6_last", 32'(sent[base + 2]), 32'h41);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rx_valid = ($urandom_range(0, 9) < 4);
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      if ($urandom_range(0, 9) == 0) busy_len = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) ign = 1;
      cycles(1);
    end
    rx_valid = 1'b0;
    hold = 1'b0;
    for (int t = 0; t < 5000 && (mq.size() != 0 || lf_due); t++) cycles(1);
    cycles(ACK_TO + 20);
    chk("rand_drained", 32'(fifo_level), 0);
    chk("rand_model", 32'(mq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
Parametrised echo path between a UART receiver and a UART transmitter. Received words are queued in a FIFO of depth DEPTH instead of a single holding register, so back-to-back RX traffic is not lost while TX is busy. A TX handshake FSM drains the FIFO through the transmitter's start/tx_ready interface and retries a start pulse that the transmitter did not take. The block sits between rUART and tUART in the FPGA top level and reports FIFO level, overflow and dropped-word count.

Parameters:
DATA_W, 8, word width of rx_data/tx_data
DEPTH, 16, FIFO entries; power of two, >= 2
CNT_W, 8, width of drop_count (saturating)
ACK_TO, 64, cycles to wait for tx_ready to fall after a start pulse before retrying

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx_data  in  DATA_W  received word, valid when rx_valid=1
rx_valid  in  1  single-cycle strobe from receiver
tx_ready  in  1  transmitter idle (1) / busy (0)
tx_data  out  DATA_W  word to transmit; stable from tx_start until tx_ready returns high
tx_start  out  1  single-cycle start pulse to transmitter
fifo_level  out  $clog2(DEPTH)+1  current number of stored words
overflow  out  1  sticky; set when a word is dropped
drop_count  out  CNT_W  dropped words, saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous) clears: FIFO pointers, fifo_level=0, tx_start=0, tx_data=0, overflow=0, drop_count=0, FSM=IDLE, retry counter=0. Reset asserted mid-transfer abandons the word; no start pulse is issued after release until the FIFO is refilled.
- Push: rx_valid=1 and (not full, or pop in same cycle) -> word written at the write pointer; visible in fifo_level next cycle.
- Full with rx_valid=1 and no pop -> word dropped, overflow<=1, drop_count+1 unless saturated. A simultaneous pop and push on a full FIFO accepts the push; level unchanged.
- Push on an empty FIFO: the earliest the word can be popped is the following cycle. There is no fall-through, so RX->tx_start latency is at least 2 cycles.
- Pointers are $clog2(DEPTH) bits and wrap naturally. fifo_level = write count minus read count, held in an explicit counter.
- TX FSM states:
  - IDLE: if FIFO non-empty and tx_ready=1 -> tx_data<=head, tx_start<=1 for one cycle, pop, clear retry counter -> WAIT_BUSY.
  - WAIT_BUSY: tx_ready=0 -> WAIT_DONE. If tx_ready stays 1 for ACK_TO cycles -> pulse tx_start again with the same tx_data, restart the counter (no pop).
  - WAIT_DONE: tx_ready=1 -> IDLE, or -> SEND_LF (feature only).
- tx_start is never high on two consecutive cycles. tx_data changes only on the IDLE->WAIT_BUSY transition.
- Each word is transmitted exactly once per successful handshake, in FIFO order.

Optional Feature:
Macro ECHO_CRLF_EN.
- Defined:
  - WAIT_DONE leaving after a word equal to 8'h0D (low 8 bits; requires DATA_W>=8) -> SEND_LF instead of IDLE.
  - SEND_LF waits for tx_ready=1, then issues tx_data=8'h0A (zero-extended) with one tx_start, no pop -> WAIT_BUSY. Retry applies as normal.
  - After the LF completes -> IDLE.
- Undefined: SEND_LF state and comparator absent; CR is echoed as a plain byte.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, WAIT_BUSY, WAIT_DONE, SEND_LF)
  - CR/LF constants
  - level-width function clog2(DEPTH)+1
- Sub-module uart_sync_fifo (DATA_W, DEPTH):
  - inputs push, pop; outputs head data, full, empty, level
  - same clk/reset
  - holds the storage array and pointers
- Top holds the FSM, retry counter and drop statistics.

Test Plan:
1. Reset, then rx 8'h41 with tx_ready=1; model transmitter drops tx_ready 1 cycle after start for 10 cycles -> exactly one tx_start, tx_data=8'h41, fifo_level returns to 0.
2. 5 rx words 8'h01..8'h05 back-to-back while tx_ready=0 -> fifo_level=5; release tx_ready -> transmitted in order 01..05, one start per word.
3. DEPTH=16, tx_ready held 0, 20 rx words -> fifo_level=16, overflow=1, drop_count=4; words 17-20 never appear on tx_data.
4. Transmitter ignores the first start (tx_ready stays 1) -> second tx_start exactly ACK_TO cycles later with the same tx_data; FIFO popped only once.
5. Assert reset during WAIT_DONE with 3 words queued -> all outputs 0 immediately; after release no tx_start until a new rx_valid.
6. ECHO_CRLF_EN defined, rx 8'h0D then 8'h41 -> tx sequence 0D, 0A, 41. Undefined -> 0D, 41.
